id_ctrl_stage: RTL and testbench

//  Registered decode stage for the ARM core: decodes mode/opcode/S, evaluates cond vs NZCV,

---
 rtl/arm_ctrl_pkg.sv | 62 ++++++
 rtl/cond_check.sv | 36 +++
 rtl/id_ctrl_stage.sv | 162 ++++++++++++++++
 tb/tb_id_ctrl_stage.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the ARM decode/execute control path.
package arm_ctrl_pkg;

    localparam logic [1:0] MODE_ALU = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;
    localparam logic [3:0] OP_MEM = 4'b0100;

    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_MUL = 4'b1010;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       wb_en;
        logic       b;
        logic       s_upd;
        logic       mul;
        logic [3:0] exe_cmd;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/cond_check.sv
// Condition-code evaluation against NZCV; shared by decode and execute.
module cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign {n, z, c, v} = nzcv;

    always_comb begin
        pass = 1'b0;
        unique case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/id_ctrl_stage.sv
// Registered ARM decode stage: decode, condition gating, bubbles and MUL issue blocking.
module id_ctrl_stage
    import arm_ctrl_pkg::*;
#(
    parameter int CMD_W       = 4,
    parameter int MUL_CYCLES  = 4,
    parameter int SUPPORT_MUL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [3:0]       opcode,
    input  logic             s,
    input  logic [3:0]       cond,
    input  logic             mul_flag,
    input  logic [3:0]       nzcv,
    input  logic             hazard,
    input  logic             flush,
    output logic             out_valid,
    output logic             out_mem_read,
    output logic             out_mem_write,
    output logic             out_wb_en,
    output logic             out_b,
    output logic             out_s_upd,
    output logic             out_mul,
    output logic [CMD_W-1:0] out_exe_cmd,
    output logic             busy
);

    localparam int CNT_W = $clog2(MUL_CYCLES);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    ctrl_t            ctrl_q, ctrl_d;

    ctrl_t dec;
    logic  dec_ok;
    logic  pass;
    logic  accept;

    cond_check u_cond (
        .cond (cond),
        .nzcv (nzcv),
        .pass (pass)
    );

    always_comb begin
        dec       = CTRL_BUBBLE;
        dec.wb_en = 1'b1;
        dec.s_upd = s;
        dec_ok    = 1'b1;
        if (mul_flag && mode == MODE_ALU) begin
            if (SUPPORT_MUL != 0) begin
                dec.mul     = 1'b1;
                dec.exe_cmd = EXE_MUL;
            end else begin
                dec_ok = 1'b0;
            end
        end else begin
            unique case (mode)
                MODE_MEM: begin
                    dec.exe_cmd = EXE_ADD;
                    dec_ok      = (opcode == OP_MEM);
                    if (s) begin
                        dec.mem_read = 1'b1;
                    end else begin
                        dec.mem_write = 1'b1;
                        dec.wb_en     = 1'b0;
                    end
                end
                MODE_BR: begin
                    dec.b     = 1'b1;
                    dec.wb_en = 1'b0;
                    dec.s_upd = 1'b0;
                end
                MODE_ALU: begin
                    unique case (opcode)
                        OP_MOV: dec.exe_cmd = EXE_MOV;
                        OP_MVN: dec.exe_cmd = EXE_MVN;
                        OP_ADD: dec.exe_cmd = EXE_ADD;
                        OP_ADC: dec.exe_cmd = EXE_ADC;
                        OP_SUB: dec.exe_cmd = EXE_SUB;
                        OP_SBC: dec.exe_cmd = EXE_SBC;
                        OP_AND: dec.exe_cmd = EXE_AND;
                        OP_ORR: dec.exe_cmd = EXE_ORR;
                        OP_EOR: dec.exe_cmd = EXE_EOR;
                        OP_CMP: begin
                            dec.exe_cmd = EXE_SUB;
                            dec.wb_en   = 1'b0;
                            dec_ok      = s;
                        end
                        OP_TST: begin
                            dec.exe_cmd = EXE_AND;
                            dec.wb_en   = 1'b0;
                            dec_ok      = s;
                        end
                        default: dec_ok = 1'b0;
                    endcase
                end
                default: dec_ok = 1'b0;
            endcase
        end
    end

    assign in_ready = rst_n && !flush && (state_q == S_IDLE) && !hazard;
    assign accept   = in_valid && in_ready;

    // Undefined or cond-failed instructions are still consumed, just not issued.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        ctrl_d  = CTRL_BUBBLE;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (state_q == S_MUL) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                state_d = S_IDLE;
            end
        end else if (accept && dec_ok && pass) begin
            valid_d = 1'b1;
            ctrl_d  = dec;
            if (dec.mul) begin
                state_d = S_MUL;
                cnt_d   = CNT_W'(MUL_CYCLES - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_BUBBLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_mem_read  = ctrl_q.mem_read;
    assign out_mem_write = ctrl_q.mem_write;
    assign out_wb_en     = ctrl_q.wb_en;
    assign out_b         = ctrl_q.b;
    assign out_s_upd     = ctrl_q.s_upd;
    assign out_mul       = ctrl_q.mul;
    assign out_exe_cmd   = CMD_W'(ctrl_q.exe_cmd);
    assign busy          = (state_q == S_MUL);

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Bench for id_ctrl_stage: directed vectors checked every cycle against a reference model.
module tb_id_ctrl_stage;

    localparam int MULC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] mode;
    logic [3:0] opcode;
    logic       s;
    logic [3:0] cond;
    logic       mul_flag;
    logic [3:0] nzcv;
    logic       hazard;
    logic       flush;
    logic       out_valid;
    logic       out_mem_read;
    logic       out_mem_write;
    logic       out_wb_en;
    logic       out_b;
    logic       out_s_upd;
    logic       out_mul;
    logic [3:0] out_exe_cmd;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ctrl_stage #(
        .CMD_W       (4),
        .MUL_CYCLES  (MULC),
        .SUPPORT_MUL (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .mode          (mode),
        .opcode        (opcode),
        .s             (s),
        .cond          (cond),
        .mul_flag      (mul_flag),
        .nzcv          (nzcv),
        .hazard        (hazard),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_mem_read  (out_mem_read),
        .out_mem_write (out_mem_write),
        .out_wb_en     (out_wb_en),
        .out_b         (out_b),
        .out_s_upd     (out_s_upd),
        .out_mul       (out_mul),
        .out_exe_cmd   (out_exe_cmd),
        .busy          (busy)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ALU opcode -> command; -1 marks an undefined opcode
    int alu_map [16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};

    // {defined, rd, wr, wb, b, s_upd, mul, cmd[3:0]}
    function automatic logic [10:0] ref_dec(input logic [1:0] m,
            input logic [3:0] op, input logic sb, input logic mf);
        logic [10:0] r;
        r = '0;
        if (mf && m == 2'b00) begin
            r[10] = 1'b1; r[7] = 1'b1; r[5] = sb; r[4] = 1'b1;
            r[3:0] = 4'hA;
        end else if (m == 2'b01 && op == 4'h4) begin
            r[10] = 1'b1; r[5] = sb; r[3:0] = 4'h2;
            if (sb) begin
                r[9] = 1'b1; r[7] = 1'b1;
            end else begin
                r[8] = 1'b1;
            end
        end else if (m == 2'b10) begin
            r[10] = 1'b1; r[6] = 1'b1;
        end else if (m == 2'b00 && alu_map[op] >= 0) begin
            r[10] = sb || !(op == 4'h8 || op == 4'hA);
            r[7]  = !(op == 4'h8 || op == 4'hA);
            r[5]  = sb;
            r[3:0] = 4'(alu_map[op]);
        end
        return r;
    endfunction

    // even codes test a flag relation, odd codes are its negation
    function automatic bit ref_pass(input logic [3:0] cd, input logic [3:0] f);
        bit n, z, c, v, r;
        {n, z, c, v} = f;
        case (cd[3:1])
            3'd0:    r = z;
            3'd1:    r = c;
            3'd2:    r = n;
            3'd3:    r = v;
            3'd4:    r = c && !z;
            3'd5:    r = (n == v);
            3'd6:    r = !z && (n == v);
            default: r = 1'b1;
        endcase
        return r ^ cd[0];
    endfunction

    bit         m_ok = 1'b0;
    bit         m_valid;
    logic [9:0] m_ctrl;
    int         m_stall;

    always @(posedge clk) begin
        logic [10:0] d;
        d = ref_dec(mode, opcode, s, mul_flag);
        m_ok = 1'b1;
        if (!rst_n || flush) begin
            m_valid = 1'b0; m_ctrl = '0; m_stall = 0;
        end else if (m_stall > 0) begin
            m_valid = 1'b0; m_ctrl = '0; m_stall--;
        end else if (in_valid && !hazard && d[10] && ref_pass(cond, nzcv)) begin
            m_valid = 1'b1; m_ctrl = d[9:0];
            if (d[4]) m_stall = MULC - 1;
        end else begin
            m_valid = 1'b0; m_ctrl = '0;
        end
    end

    always @(negedge clk) begin
        logic [12:0] exp_v, act_v;
        if (m_ok) begin
            exp_v = {m_valid, m_ctrl, m_stall > 0,
                     rst_n && !flush && m_stall == 0 && !hazard};
            act_v = {out_valid, out_mem_read, out_mem_write, out_wb_en, out_b,
                     out_s_upd, out_mul, out_exe_cmd, busy, in_ready};
            chk("cycle", 32'(act_v), 32'(exp_v));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic put(input bit v, input logic [1:0] m, input logic [3:0] op,
                       input bit sb, input logic [3:0] cd, input bit mf);
        in_valid = v; mode = m; opcode = op; s = sb; cond = cd; mul_flag = mf;
    endtask

    typedef struct {
        logic [1:0] m;
        logic [3:0] op;
        bit         sb;
        logic [3:0] cd;
        bit         mf;
        logic [3:0] f;
        bit         v;
        bit         hz;
        bit         fl;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [1:0] m, input logic [3:0] op,
            input bit sb, input logic [3:0] cd, input bit mf,
            input logic [3:0] f, input bit v, input bit hz, input bit fl);
        vec_t t;
        t.m = m; t.op = op; t.sb = sb; t.cd = cd; t.mf = mf;
        t.f = f; t.v = v; t.hz = hz; t.fl = fl;
        return t;
    endfunction

    initial begin
        rst_n = 1'b0; nzcv = 4'h0; hazard = 1'b0; flush = 1'b0;
        put(1, 2'b00, 4'h4, 0, 4'hE, 0);
        repeat (3) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);

        rst_n = 1'b1;
        #1 chk("add_ready", in_ready, 1);
        tick();
        chk("add_valid", out_valid, 1);
        chk("add_cmd", out_exe_cmd, 4'h2);
        chk("add_wb", out_wb_en, 1);

        put(1, 2'b01, 4'h4, 1, 4'h0, 0);
        #1 chk("ldr_ready", in_ready, 1);
        tick();
        chk("ldr_fail_valid", out_valid, 0);
        nzcv = 4'b0100;
        tick();
        chk("ldr_valid", out_valid, 1);
        chk("ldr_rd", out_mem_read, 1);
        chk("ldr_cmd", out_exe_cmd, 4'h2);

        nzcv = 4'h0;
        put(1, 2'b00, 4'h0, 0, 4'hE, 1);
        tick();
        chk("mul_flag", out_mul, 1);
        chk("mul_cmd", out_exe_cmd, 4'hA);
        chk("mul_busy", busy, 1);
        put(1, 2'b00, 4'h4, 0, 4'hE, 0);
        #1 chk("mul_ready", in_ready, 0);
        repeat (2) begin
            tick();
            chk("mulw_busy", busy, 1);
            chk("mulw_valid", out_valid, 0);
            chk("mulw_ready", in_ready, 0);
        end
        tick();
        chk("mul_end_busy", busy, 0);
        chk("mul_end_valid", out_valid, 0);
        chk("mul_end_ready", in_ready, 1);
        tick();
        chk("post_mul_add", out_exe_cmd, 4'h2);

        put(1, 2'b00, 4'hD, 0, 4'hE, 0);
        hazard = 1'b1;
        #1 chk("haz_ready", in_ready, 0);
        tick();
        chk("haz_valid", out_valid, 0);
        hazard = 1'b0;
        tick();
        chk("mov_valid", out_valid, 1);
        chk("mov_cmd", out_exe_cmd, 4'h1);

        put(1, 2'b00, 4'h0, 0, 4'hE, 1);
        tick();
        put(1, 2'b00, 4'h2, 0, 4'hE, 0);
        tick();
        flush = 1'b1;
        #1 chk("flush_ready", in_ready, 0);
        tick();
        chk("flush_busy", busy, 0);
        chk("flush_valid", out_valid, 0);
        flush = 1'b0;
        tick();
        chk("sub_valid", out_valid, 1);
        chk("sub_cmd", out_exe_cmd, 4'h4);

        tbl.push_back(mk(2'b00, 4'hF, 0, 4'hE, 0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(2'b00, 4'h5, 1, 4'hE, 0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(2'b00, 4'h6, 0, 4'hE, 0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(2'b00, 4'h0, 0, 4'hE, 0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(2'b00, 4'hC, 0, 4'hE, 0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(2'b00, 4'h1, 1, 4'hE, 0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(2'b00, 4'hA, 1, 4'hE, 0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(2'b00, 4'hA, 0, 4'hE, 0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(2'b00, 4'h8, 1, 4'hE, 0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(2'b01, 4'h4, 0, 4'hE, 0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(2'b10, 4'h3, 1, 4'hE, 0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(2'b11, 4'h4, 0, 4'hE, 0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(2'b00, 4'h7, 0, 4'hE, 0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(2'b01, 4'h0, 1, 4'hE, 0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(2'b00, 4'h4, 0, 4'hF, 0, 4'hF, 1, 0, 0));
        tbl.push_back(mk(2'b00, 4'h4, 0, 4'h8, 0, 4'h2, 1, 0, 0));
        tbl.push_back(mk(2'b00, 4'h4, 0, 4'h9, 0, 4'h2, 1, 0, 0));
        tbl.push_back(mk(2'b00, 4'h4, 0, 4'hA, 0, 4'h9, 1, 0, 0));
        tbl.push_back(mk(2'b00, 4'h4, 0, 4'hB, 0, 4'h8, 1, 0, 0));
        tbl.push_back(mk(2'b00, 4'h4, 0, 4'hC, 0, 4'h4, 1, 0, 0));
        tbl.push_back(mk(2'b00, 4'h4, 0, 4'hD, 0, 4'h4, 1, 0, 0));
        tbl.push_back(mk(2'b00, 4'h4, 0, 4'h6, 0, 4'h1, 1, 0, 0));
        tbl.push_back(mk(2'b00, 4'h4, 0, 4'h7, 0, 4'h1, 1, 0, 0));
        tbl.push_back(mk(2'b00, 4'h4, 0, 4'h4, 0, 4'h8, 1, 0, 0));
        tbl.push_back(mk(2'b00, 4'h4, 0, 4'h5, 0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(2'b00, 4'h4, 0, 4'h2, 0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(2'b00, 4'h4, 0, 4'h3, 0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(2'b00, 4'h4, 0, 4'h1, 0, 4'h4, 1, 0, 0));
        tbl.push_back(mk(2'b00, 4'h4, 0, 4'hE, 0, 4'h0, 1, 0, 1));
        tbl.push_back(mk(2'b00, 4'h4, 0, 4'hE, 0, 4'h0, 0, 1, 0));
        tbl.push_back(mk(2'b00, 4'h0, 0, 4'h0, 1, 4'h0, 1, 0, 0));
        tbl.push_back(mk(2'b00, 4'h0, 1, 4'hE, 1, 4'h0, 1, 0, 0));
        tbl.push_back(mk(2'b00, 4'h4, 0, 4'hE, 0, 4'h0, 1, 1, 0));
        tbl.push_back(mk(2'b00, 4'h4, 0, 4'hE, 0, 4'h0, 1, 0, 0));

        foreach (tbl[i]) begin
            put(tbl[i].v, tbl[i].m, tbl[i].op, tbl[i].sb, tbl[i].cd, tbl[i].mf);
            nzcv = tbl[i].f; hazard = tbl[i].hz; flush = tbl[i].fl;
            tick();
        end

        put(0, 2'b00, 4'h0, 0, 4'hE, 0);
        hazard = 1'b0; flush = 1'b0;
        repeat (6) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
